// File: rtl/qmult_seq_if.sv
// qmult_seq_if: operand/result handshake bundle for the qmult_seq multiplier.
// Rev 1.0
`default_nettype none

interface qmult_seq_if #(
  parameter int N = 32
);
  logic         i_start;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic         i_clr_sticky;
  logic         o_busy;
  logic         o_complete;
  logic [N-1:0] o_result;
  logic         o_ovr;
  logic         o_ovr_sticky;

  modport master (
    output i_start, i_multiplicand, i_multiplier, i_clr_sticky,
    input  o_busy, o_complete, o_result, o_ovr, o_ovr_sticky
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier, i_clr_sticky,
    output o_busy, o_complete, o_result, o_ovr, o_ovr_sticky
  );
endinterface

`default_nettype wire

// File: rtl/qmult_seq.sv
// qmult_seq: iterative shift-add sign-magnitude Q-format multiplier.
// Define QMULT_SAT_EN to saturate the magnitude on overflow. Rev 1.0
`default_nettype none

module qmult_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  qmult_seq_if.slave bus
);
  localparam int M  = N - 1;
  localparam int PW = 2 * M;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            load;
  logic            step;
  logic            finish;

  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [M-1:0]    mplier;
  logic            sign;

  logic            complete;
  logic [N-1:0]    result;
  logic            ovr;
  logic            sticky;

  logic            prod_ovr;
  logic [M-1:0]    mag_trunc;
  logic [M-1:0]    mag;
  logic            res_sign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator holds the full 2(N-1)-bit magnitude product once RUN ends.
  assign prod_ovr  = |(acc >> (Q + M));
  assign mag_trunc = acc[Q +: M];

`ifdef QMULT_SAT_EN
  assign mag = prod_ovr ? {M{1'b1}} : mag_trunc;
`else
  assign mag = mag_trunc;
`endif

  // A zero magnitude never carries a negative sign.
  assign res_sign = sign & (|mag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sign     <= 1'b0;
      complete <= 1'b0;
      result   <= '0;
      ovr      <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      if (load) begin
        acc    <= '0;
        mcand  <= PW'(bus.i_multiplicand[M-1:0]);
        mplier <= bus.i_multiplier[M-1:0];
        sign   <= bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
        count  <= CW'(M);
      end else if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
      end

      complete <= finish;
      if (finish) begin
        result <= {res_sign, mag};
        ovr    <= prod_ovr;
      end

      if (bus.i_clr_sticky) begin
        sticky <= 1'b0;
      end else if (finish && prod_ovr) begin
        sticky <= 1'b1;
      end
    end
  end

  assign bus.o_busy       = (state == RUN);
  assign bus.o_complete   = complete;
  assign bus.o_result     = result;
  assign bus.o_ovr        = ovr;
  assign bus.o_ovr_sticky = sticky;

endmodule

`default_nettype wire

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: directed checks of qmult_seq at Q=7, N=16.
// Rev 1.0
`default_nettype none

module tb_qmult_seq;
  localparam int Q = 7;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_res = 16'h0000;

  qmult_seq_if #(.N(N)) bus ();

  qmult_seq #(.Q(Q), .N(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and follows it to completion; called at a negedge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_r, input logic exp_o, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    @(negedge clk);
    bus.i_start        = 1'b0;
    bus.i_multiplicand = 16'($urandom);
    bus.i_multiplier   = 16'($urandom);
    lat      = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) check({tag, "_hold"}, bus.o_result, last_res);
      if (bus.o_busy) busy_cnt++;
      if (bus.o_complete) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, 16);
    check({tag, "_busy"}, busy_cnt, 15);
    check({tag, "_res"}, bus.o_result, exp_r);
    check({tag, "_ovr"}, bus.o_ovr, exp_o);
    last_res = exp_r;
    @(negedge clk);
    check({tag, "_pulse"}, bus.o_complete, 1'b0);
    check({tag, "_held"}, bus.o_result, exp_r);
  endtask

  initial begin
    int nc;
    int lat1;
    int lat2;
    logic [15:0] got1;
    logic [15:0] got2;

    bus.i_start        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;
    bus.i_clr_sticky   = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",   bus.o_busy,       1'b0);
    check("rst_cmpl",   bus.o_complete,   1'b0);
    check("rst_result", bus.o_result,     16'h0000);
    check("rst_ovr",    bus.o_ovr,        1'b0);
    check("rst_sticky", bus.o_ovr_sticky, 1'b0);

    run_op(16'h0192, 16'h0080, 16'h0192, 1'b0, "pi_x1");
    run_op(16'h8192, 16'h0080, 16'h8192, 1'b0, "neg_x_pos");
    run_op(16'h8192, 16'h8080, 16'h0192, 1'b0, "neg_x_neg");
    run_op(16'h8000, 16'h0100, 16'h0000, 1'b0, "negzero");
    run_op(16'h0001, 16'h0001, 16'h0000, 1'b0, "underflow");
    run_op(16'h00C0, 16'h00C0, 16'h0120, 1'b0, "1p5_sq");
    run_op(16'h7FFF, 16'h0080, 16'h7FFF, 1'b0, "max_no_ovr");
    check("sticky_clean", bus.o_ovr_sticky, 1'b0);

`ifdef QMULT_SAT_EN
    run_op(16'h4000, 16'h0400, 16'h7FFF, 1'b1, "ovr_pos");
`else
    run_op(16'h4000, 16'h0400, 16'h0000, 1'b1, "ovr_pos");
`endif
    check("sticky_set", bus.o_ovr_sticky, 1'b1);

    run_op(16'h0192, 16'h0080, 16'h0192, 1'b0, "after_ovr");
    check("sticky_keep", bus.o_ovr_sticky, 1'b1);

    bus.i_clr_sticky = 1'b1;
    @(negedge clk);
    bus.i_clr_sticky = 1'b0;
    check("sticky_clr", bus.o_ovr_sticky, 1'b0);

`ifdef QMULT_SAT_EN
    run_op(16'hC000, 16'h0400, 16'hFFFF, 1'b1, "ovr_neg");
    run_op(16'h7FFF, 16'h0081, 16'h7FFF, 1'b1, "ovr_edge");
`else
    run_op(16'hC000, 16'h0400, 16'h0000, 1'b1, "ovr_neg");
    run_op(16'h7FFF, 16'h0081, 16'h00FE, 1'b1, "ovr_edge");
`endif

    // Clear and an overflow completion in the same cycle: clear wins.
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 16'h4000;
    bus.i_multiplier   = 16'h0400;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (15) @(negedge clk);
    bus.i_clr_sticky = 1'b1;
    @(negedge clk);
    bus.i_clr_sticky = 1'b0;
    check("clr_pri_cmpl",   bus.o_complete,   1'b1);
    check("clr_pri_ovr",    bus.o_ovr,        1'b1);
    check("clr_pri_sticky", bus.o_ovr_sticky, 1'b0);
`ifdef QMULT_SAT_EN
    last_res = 16'h7FFF;
`else
    last_res = 16'h0000;
`endif

    // Busy handling: a start during RUN is dropped; a start right after completion is taken.
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 16'h00C0;
    bus.i_multiplier   = 16'h00C0;
    @(negedge clk);
    nc   = 0;
    lat1 = -1;
    lat2 = -1;
    got1 = '0;
    got2 = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin
        bus.i_start        = 1'b1;
        bus.i_multiplicand = 16'h7FFF;
        bus.i_multiplier   = 16'h7FFF;
      end else if (i == 17) begin
        bus.i_start        = 1'b1;
        bus.i_multiplicand = 16'h0192;
        bus.i_multiplier   = 16'h0080;
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_complete) begin
        nc++;
        if (lat1 < 0) begin
          lat1 = i;
          got1 = bus.o_result;
        end else begin
          lat2 = i;
          got2 = bus.o_result;
        end
      end
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    check("busy_ncmpl", nc, 2);
    check("busy_lat1",  lat1, 16);
    check("busy_res1",  got1, 16'h0120);
    check("busy_lat2",  lat2, 34);
    check("busy_res2",  got2, 16'h0192);
    last_res = 16'h0192;

    // Reset during RUN aborts without a completion pulse.
    run_op(16'h4000, 16'h0400, 16'h7FFF & {16{1'b0}} |
`ifdef QMULT_SAT_EN
           16'h7FFF,
`else
           16'h0000,
`endif
           1'b1, "pre_rst");
    run_op(16'h00C0, 16'h00C0, 16'h0120, 1'b0, "pre_rst2");
    check("pre_rst_sticky", bus.o_ovr_sticky, 1'b1);
    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 16'h0192;
    bus.i_multiplier   = 16'h0080;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",   bus.o_busy,       1'b0);
    check("midrst_result", bus.o_result,     16'h0000);
    check("midrst_ovr",    bus.o_ovr,        1'b0);
    check("midrst_sticky", bus.o_ovr_sticky, 1'b0);
    nc = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.o_complete || bus.o_busy) nc++;
      @(negedge clk);
    end
    check("midrst_quiet", nc, 0);
    last_res = 16'h0000;
    run_op(16'h8192, 16'h0080, 16'h8192, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/qmult_seq.md
Name: qmult_seq

Overview:
- Sequential, parametrised successor to the combinational qmult fixed-point multiplier.
- Operands and result are sign-magnitude Q-format words: bit N-1 is the sign; bits N-2:0 are the magnitude, with Q fractional bits.
- Iterative shift-add datapath with a start/complete handshake, replacing the wide single-cycle multiplier in timing-critical paths of the fixed-point calculator.
- Adds zero-sign normalisation, a sticky overflow flag and optional saturation.

Parameters:
- Q, 15, number of fractional bits; legal range 0 <= Q <= N-2.
- N, 32, total word width including sign; N >= 4.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_multiplicand  in  N  sign-magnitude operand A; captured when i_start is accepted.
- i_multiplier  in  N  sign-magnitude operand B; captured when i_start is accepted.
- o_busy  out  1  high while in RUN.
- o_complete  out  1  one-cycle pulse; o_result and o_ovr are valid.
- o_result  out  N  sign-magnitude product; held until the next completion.
- o_ovr  out  1  overflow flag for the last operation; held with o_result.
- o_ovr_sticky  out  1  OR of every o_ovr since reset or since i_clr_sticky.
- i_clr_sticky  in  1  clears o_ovr_sticky on the next edge. A clear takes priority over a set in the same cycle.

Behaviour:
- Reset: i_rst high at a rising edge drives the FSM to IDLE. All outputs go to 0: o_busy, o_complete, o_result, o_ovr and o_ovr_sticky. The internal accumulator and counter are also cleared. Reset asserted during RUN aborts the operation with no completion pulse.
- States:
  - IDLE: i_start=1 captures both operand magnitudes. The sign is captured as A[N-1]^B[N-1]. Counter loads N-1; next state is RUN.
  - RUN: one multiplier magnitude bit per cycle, LSB first. If the bit is 1, the shifted multiplicand is added into a 2(N-1)-bit accumulator. The counter decrements; when it reaches 0, next state is DONE.
  - DONE: o_result, o_ovr and o_complete update on entry. Next state is IDLE unconditionally.
- Latency: i_start is sampled at edge k. o_busy is high for cycles k+1 through k+N-1. o_complete is high for exactly one cycle, after edge k+N. Initiation interval is N+1 cycles.
- i_start while in RUN or DONE is ignored; the request is not queued. Operand inputs are don't-care outside the accepting edge.
- Arithmetic:
  - P is the full 2(N-1)-bit magnitude product.
  - Result magnitude = P[Q+N-2 : Q], truncated toward zero with no rounding.
  - o_ovr = 1 if any bit of P above Q+N-2 is 1.
- Sign rules:
  - o_result[N-1] is the captured sign, except that a zero magnitude forces it to 0 (no negative zero).
  - An input of negative zero is treated as zero.
- o_result and o_ovr change only on the o_complete cycle or on reset.
- o_ovr_sticky is set on the o_complete cycle when o_ovr=1.

Optional Feature:
- Macro: QMULT_SAT_EN.
- Defined: on overflow, the magnitude saturates to all-ones in bits N-2:0 and the sign keeps the captured sign. o_ovr is still asserted.
- Undefined: on overflow, the magnitude is the truncated slice P[Q+N-2:Q], so the high bits are lost. If that slice is zero, the sign is forced to 0 under the normal sign rule.
- Latency and handshake are identical in both builds.

Test Plan:
- Q=7, N=16: A=0x0192 (3.140625), B=0x0080 (1.0), start -> exactly 16 cycles later o_complete=1, o_result=0x0192, o_ovr=0; o_busy is high for 15 cycles.
- Sign cases: 0x8192 x 0x0080 -> 0x8192. Then 0x8192 x 0x8080 -> 0x0192. Then 0x8000 x 0x0100 -> 0x0000 with sign 0.
- Overflow: 0x4000 (128.0) x 0x0400 (8.0).
  - With QMULT_SAT_EN: o_result=0x7FFF, o_ovr=1, o_ovr_sticky=1.
  - Without QMULT_SAT_EN: o_result=0x0000, o_ovr=1.
  - Afterwards, pulse i_clr_sticky -> o_ovr_sticky=0.
- Underflow truncation: 0x0001 x 0x0001 -> o_result=0x0000, o_ovr=0. Also 0x00C0 (1.5) x 0x00C0 -> 0x0120 (2.25).
- Busy handling: second i_start with new operands 3 cycles after the first -> ignored; exactly one o_complete, carrying the first result. An i_start on the cycle after o_complete is accepted.
- Reset mid-operation: assert i_rst at cycle 5 of RUN -> next cycle o_busy=0, o_result=0, no o_complete. A new start afterwards completes normally with correct latency.
